prime_sim: RTL and testbench

PRIME_SIM -- requirements
Module: prime_sim

---
 rtl/prime_sim_pkg.sv | 25 ++
 rtl/prime_sim_bitram.sv | 26 ++
 rtl/prime_sim.sv | 157 +++++++++++++++
 tb/tb_prime_sim.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prime_sim_pkg.sv
// Shared types and constants for the prime_sim sieve engine.
`timescale 1ns/1ps
package prime_sim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_OUTER,
    S_CHECK,
    S_MARK,
    S_COUNT,
    S_DONE
  } state_e;

  localparam int LIMIT_DEF = 1024;
  localparam int RESULT_W  = 32;
  // j can overshoot LIMIT by up to i, so one bit beyond 65536 is needed.
  localparam int IDX_W     = 18;
  localparam int SQ_W      = 34;

  function automatic int addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prime_sim_bitram.sv
// Single-port DEPTH x 1 bit RAM: synchronous write, registered read-first output.
`timescale 1ns/1ps
module prime_sim_bitram
  import prime_sim_pkg::*;
#(
  parameter int DEPTH = LIMIT_DEF,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic          wdata_i,
  output logic          rdata_o
);

  logic mem [DEPTH];
  logic rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prime_sim.sv
// Sieve of Eratosthenes engine: counts primes below LIMIT into result, then sets finish_flag.
`timescale 1ns/1ps
module prime_sim
  import prime_sim_pkg::*;
#(
  parameter int LIMIT = LIMIT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_req,
  output logic                run_busy,
  input  logic                start_req,
  output logic                start_busy,
  input  logic                join_req,
  output logic                join_busy,
  input  logic                yield_req,
  output logic                yield_busy,
  output logic                finish_flag_out,
  input  logic                finish_flag_in,
  input  logic                finish_flag_we,
  output logic [RESULT_W-1:0] result_out,
  input  logic [RESULT_W-1:0] result_in,
  input  logic                result_we
);

  localparam int               AW       = addr_w(LIMIT);
  localparam logic [IDX_W-1:0] LIM_IDX  = IDX_W'(LIMIT);
  localparam logic [IDX_W-1:0] LIM_LAST = IDX_W'(LIMIT - 1);
  localparam logic [SQ_W-1:0]  LIM_SQ   = SQ_W'(LIMIT);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    i_q, i_d, j_q, j_d;
  logic [RESULT_W-1:0] acc_q, acc_d, result_q, result_d;
  logic                flag_q, flag_d;
  logic                cnt_vld_q, cnt_vld_d;
  logic [SQ_W-1:0]     i_sq;
  logic [IDX_W-1:0]    j_step;
  logic [AW-1:0]       ram_addr;
  logic                ram_we, ram_wdata, ram_rdata;
  logic                unused_inputs;

  assign unused_inputs = join_req ^ yield_req;

  assign i_sq   = SQ_W'(i_q) * SQ_W'(i_q);
  assign j_step = j_q + i_q;

  prime_sim_bitram #(.DEPTH(LIMIT), .AW(AW)) u_bitram (
    .clk     (clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    cnt_vld_d = 1'b0;
    ram_addr  = AW'(j_q);
    ram_we    = 1'b0;
    ram_wdata = 1'b0;
    result_d  = result_we ? result_in : result_q;
    flag_d    = finish_flag_we ? finish_flag_in : flag_q;
    unique case (state_q)
      S_IDLE: begin
        if (run_req || start_req) begin
          state_d = S_INIT;
          j_d     = '0;
          acc_d   = '0;
        end
      end
      S_INIT: begin
        ram_we    = 1'b1;
        ram_wdata = 1'b1;
        if (j_q == LIM_LAST) begin
          i_d     = IDX_W'(2);
          state_d = S_OUTER;
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      S_OUTER: begin
        // Address issued here; RAM data is valid in CHECK on the next cycle.
        ram_addr = AW'(i_q);
        if (i_sq >= LIM_SQ) begin
          j_d     = IDX_W'(2);
          state_d = S_COUNT;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (ram_rdata) begin
          j_d     = i_sq[IDX_W-1:0];
          state_d = S_MARK;
        end else begin
          i_d     = i_q + IDX_W'(1);
          state_d = S_OUTER;
        end
      end
      S_MARK: begin
        ram_we = 1'b1;
        j_d    = j_step;
        if (j_step >= LIM_IDX) begin
          i_d     = i_q + IDX_W'(1);
          state_d = S_OUTER;
        end
      end
      S_COUNT: begin
        // Reads are pipelined one deep; cnt_vld_q marks the bit arriving this cycle.
        if (cnt_vld_q) acc_d = acc_q + RESULT_W'(ram_rdata);
        if (j_q < LIM_IDX) begin
          j_d       = j_q + IDX_W'(1);
          cnt_vld_d = 1'b1;
        end else if (!cnt_vld_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        result_d = acc_q;
        flag_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      flag_q    <= 1'b0;
      cnt_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      flag_q    <= flag_d;
      cnt_vld_q <= cnt_vld_d;
    end
  end

  assign run_busy        = (state_q != S_IDLE);
  assign start_busy      = run_busy;
  assign join_busy       = run_busy;
  assign yield_busy      = 1'b0;
  assign finish_flag_out = flag_q;
  assign result_out      = result_q;

endmodule

// File: tb/tb_prime_sim.sv
// Randomized self-checking bench for prime_sim against a trial-division prime count.
`timescale 1ns/1ps
module tb_prime_sim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        run_req, start_req, join_req, yield_req;
  logic        ff_in, ff_we, res_we;
  logic [31:0] res_in;
  logic        run_busy, start_busy, join_busy, yield_busy, ff_out;
  logic [31:0] res_out;

  logic        s_run;
  logic        s_busy [3];
  logic        s_sbusy[3];
  logic        s_jbusy[3];
  logic        s_ybusy[3];
  logic        s_ff   [3];
  logic [31:0] s_res  [3];
  int          lims   [3];

  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;

  prime_sim #(.LIMIT(1024)) dut (
    .clk(clk), .reset(reset),
    .run_req(run_req), .run_busy(run_busy),
    .start_req(start_req), .start_busy(start_busy),
    .join_req(join_req), .join_busy(join_busy),
    .yield_req(yield_req), .yield_busy(yield_busy),
    .finish_flag_out(ff_out), .finish_flag_in(ff_in), .finish_flag_we(ff_we),
    .result_out(res_out), .result_in(res_in), .result_we(res_we)
  );

  prime_sim #(.LIMIT(11)) dut11 (
    .clk(clk), .reset(reset),
    .run_req(s_run), .run_busy(s_busy[0]),
    .start_req(1'b0), .start_busy(s_sbusy[0]),
    .join_req(1'b0), .join_busy(s_jbusy[0]),
    .yield_req(1'b0), .yield_busy(s_ybusy[0]),
    .finish_flag_out(s_ff[0]), .finish_flag_in(1'b0), .finish_flag_we(1'b0),
    .result_out(s_res[0]), .result_in(32'd0), .result_we(1'b0)
  );

  prime_sim #(.LIMIT(2)) dut2 (
    .clk(clk), .reset(reset),
    .run_req(s_run), .run_busy(s_busy[1]),
    .start_req(1'b0), .start_busy(s_sbusy[1]),
    .join_req(1'b0), .join_busy(s_jbusy[1]),
    .yield_req(1'b0), .yield_busy(s_ybusy[1]),
    .finish_flag_out(s_ff[1]), .finish_flag_in(1'b0), .finish_flag_we(1'b0),
    .result_out(s_res[1]), .result_in(32'd0), .result_we(1'b0)
  );

  prime_sim #(.LIMIT(3)) dut3 (
    .clk(clk), .reset(reset),
    .run_req(s_run), .run_busy(s_busy[2]),
    .start_req(1'b0), .start_busy(s_sbusy[2]),
    .join_req(1'b0), .join_busy(s_jbusy[2]),
    .yield_req(1'b0), .yield_busy(s_ybusy[2]),
    .finish_flag_out(s_ff[2]), .finish_flag_in(1'b0), .finish_flag_we(1'b0),
    .result_out(s_res[2]), .result_in(32'd0), .result_we(1'b0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_primes(input int n);
    int c = 0;
    for (int k = 2; k < n; k++) begin
      bit p = 1'b1;
      for (int d = 2; d * d <= k; d++) if (k % d == 0) p = 1'b0;
      if (p) c++;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the main DUT to leave busy; returns cycles spent busy after the start edge.
  task automatic wait_main(input string tag, output int cyc);
    cyc = 0;
    while (run_busy === 1'b1 && cyc < 8 * 1024 + 16) begin
      tick();
      cyc++;
    end
    check({tag, "_finished"}, 32'(run_busy === 1'b0), 32'd1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("yield_busy", 32'(yield_busy), 32'd0);
      check("start_mirror", 32'(start_busy), 32'(run_busy));
      check("join_mirror", 32'(join_busy), 32'(run_busy));
      for (int k = 0; k < 3; k++) begin
        check("s_yield_busy", 32'(s_ybusy[k]), 32'd0);
        check("s_mirror", 32'(s_sbusy[k] & s_jbusy[k]), 32'(s_busy[k]));
      end
    end
  end

  initial begin
    join_req  = 1'b0;
    yield_req = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      join_req  = 1'($urandom_range(0, 1));
      yield_req = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [31:0] v;
    int cyc, low_run, gaps, exp_main;
    int scyc[3];
    bit seen_high;
    lims     = '{11, 2, 3};
    exp_main = ref_primes(1024);
    reset = 1'b1; run_req = 1'b0; start_req = 1'b0;
    ff_in = 1'b0; ff_we = 1'b0; res_we = 1'b0; res_in = '0; s_run = 1'b0;

    repeat (3) tick();
    mon_en = 1'b1;
    check("rst_result", res_out, 32'd0);
    check("rst_flag", 32'(ff_out), 32'd0);
    check("rst_busy", 32'(run_busy), 32'd0);
    reset = 1'b0;
    repeat ($urandom_range(1, 4)) tick();
    check("idle_no_req", 32'(run_busy), 32'd0);

    // Small LIMIT instances run in parallel.
    s_run = 1'b1;
    tick();
    s_run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("s_busy_start", 32'(s_busy[k]), 32'd1);
      scyc[k] = 0;
    end
    for (int c = 1; c <= 300; c++) begin
      for (int k = 0; k < 3; k++) if (s_busy[k] === 1'b1) scyc[k] = c;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      check("s_result", s_res[k], 32'(ref_primes(lims[k])));
      check("s_flag", 32'(s_ff[k]), 32'd1);
      check("s_latency", 32'(scyc[k] + 1 <= 8 * lims[k] + 16), 32'd1);
    end

    // First full run.
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    check("main_busy", 32'(run_busy), 32'd1);
    wait_main("run1", cyc);
    check("run1_result", res_out, 32'(exp_main));
    check("run1_flag", 32'(ff_out), 32'd1);
    check("run1_latency", 32'(cyc + 1 <= 8 * 1024 + 16), 32'd1);

    // External writes while idle.
    for (int k = 0; k < 4; k++) begin
      v = (k == 0) ? 32'hDEADBEEF : $urandom;
      res_in = v; res_we = 1'b1;
      tick();
      res_we = 1'b0;
      check("res_write", res_out, v);
      repeat ($urandom_range(0, 3)) tick();
      check("res_hold_idle", res_out, v);
    end
    ff_in = 1'b0; ff_we = 1'b1; tick(); ff_we = 1'b0;
    check("flag_clear", 32'(ff_out), 32'd0);
    ff_in = 1'b1; ff_we = 1'b1; tick(); ff_we = 1'b0;
    check("flag_set", 32'(ff_out), 32'd1);
    ff_in = 1'b0; ff_we = 1'b1; tick(); ff_we = 1'b0;
    check("flag_clear2", 32'(ff_out), 32'd0);

    // Run via start_req with a result write during the run.
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    repeat ($urandom_range(5, 50)) tick();
    v = $urandom;
    res_in = v; res_we = 1'b1;
    tick();
    res_we = 1'b0;
    check("res_write_run", res_out, v);
    check("flag_low_run", 32'(ff_out), 32'd0);
    wait_main("run2", cyc);
    check("run2_result", res_out, 32'(exp_main));
    check("run2_flag", 32'(ff_out), 32'd1);

    // Abort deep in the marking phase.
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    repeat (1100 + $urandom_range(0, 200)) tick();
    check("flag_kept_run", 32'(ff_out), 32'd1);
    check("busy_mid", 32'(run_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_result", res_out, 32'd0);
    check("abort_flag", 32'(ff_out), 32'd0);
    check("abort_busy", 32'(run_busy), 32'd0);
    run_req = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    run_req = 1'b0;
    check("rerun_busy", 32'(run_busy), 32'd1);
    cyc = 0;
    while (run_busy === 1'b1 && cyc < 8 * 1024 + 16) begin
      check("rerun_result_zero", res_out, 32'd0);
      check("rerun_flag_zero", 32'(ff_out), 32'd0);
      tick();
      cyc++;
    end
    check("rerun_finished", 32'(run_busy), 32'd0);
    check("rerun_result", res_out, 32'(exp_main));
    check("rerun_flag", 32'(ff_out), 32'd1);

    // Back-to-back runs with run_req held.
    run_req = 1'b1;
    low_run = 0; gaps = 0; seen_high = 1'b0;
    for (int c = 0; c < 9000; c++) begin
      tick();
      check("b2b_result", res_out, 32'(exp_main));
      if (run_busy !== 1'b1) begin
        low_run++;
      end else begin
        if (seen_high && low_run > 0) begin
          check("b2b_gap", 32'(low_run), 32'd1);
          gaps++;
        end
        low_run = 0;
        seen_high = 1'b1;
      end
    end
    check("b2b_gap_count", 32'(gaps >= 2), 32'd1);
    run_req = 1'b0;
    tick();
    wait_main("final", cyc);
    check("final_result", res_out, 32'(exp_main));

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
